// File: rtl/approx_div_pkg.sv
// approx_div_pkg: shared FSM states, operand widths and PREC range check for approx_div
package approx_div_pkg;
  localparam int DIVIDEND_W = 64;
  localparam int DIVISOR_W = 32;
  localparam int QUOT_W = 64;
  typedef enum logic [2:0] {IDLE, NORM, ITER, ROUND, DONE} state_t;
  function automatic bit prec_legal(input int p);
    return p >= 1 && p <= QUOT_W;
  endfunction
endpackage

// File: rtl/lead_one_enc.sv
// lead_one_enc: position of the most significant set bit; output only meaningful for nonzero x
module lead_one_enc #(
  parameter int W = 64
) (
  input  logic [W-1:0]         x,
  output logic [$clog2(W)-1:0] pos
);
  always_comb begin
    pos = '0;
    for (int k = 0; k < W; k++)
      if (x[k]) pos = k[$clog2(W)-1:0];
  end
endmodule

// File: rtl/approx_div.sv
// approx_div: PREC-bit leading-one-aligned restoring divider; APPROX_DIV_ROUND_EN adds a half-up ROUND step
module approx_div
  import approx_div_pkg::*;
#(
  parameter int PREC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  div_by_zero,
  output logic                  approx
);
  localparam int IW = $clog2(DIVIDEND_W);
  if (!prec_legal(PREC)) begin : g_prec_bad
    $error("approx_div: PREC must be in 1..64");
  end
  state_t state;
  logic [DIVIDEND_W-1:0] n_r, r, d_sh;
  logic [DIVISOR_W-1:0] d_r;
  logic [IW-1:0] i, ln, s;
  logic [$clog2(DIVISOR_W)-1:0] ld;
  logic [IW:0] cnt, s1, nb;
  logic ge;
  lead_one_enc #(.W(DIVIDEND_W)) u_lo_n (.x(n_r), .pos(ln));
  lead_one_enc #(.W(DIVISOR_W)) u_lo_d (.x(d_r), .pos(ld));
  assign s = ln - IW'(ld);
  assign s1 = {1'b0, s} + 1'b1;
  assign nb = s1 > (IW+1)'(PREC) ? (IW+1)'(PREC) : s1;
  assign d_sh = DIVIDEND_W'(d_r) << i;
  // shifting R down instead of D up keeps the compare within 64 bits
  assign ge = (r >> i) >= DIVIDEND_W'(d_r);
`ifdef APPROX_DIV_ROUND_EN
  logic [QUOT_W:0] rsum;
  assign rsum = {1'b0, quotient} + ((QUOT_W+1)'(1) << ({1'b0, i} + 1'b1));
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      quotient <= '0;
      div_by_zero <= 1'b0;
      approx <= 1'b0;
      n_r <= '0;
      d_r <= '0;
      r <= '0;
      i <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          n_r <= dividend;
          d_r <= divisor;
          in_ready <= 1'b0;
          quotient <= '0;
          div_by_zero <= 1'b0;
          approx <= 1'b0;
          state <= NORM;
        end
        NORM: if (d_r == '0) begin
          quotient <= '1;
          div_by_zero <= 1'b1;
          out_valid <= 1'b1;
          state <= DONE;
        end else if (n_r < DIVIDEND_W'(d_r)) begin
          out_valid <= 1'b1;
          state <= DONE;
        end else begin
          r <= n_r;
          i <= s;
          cnt <= nb;
          approx <= s1 > (IW+1)'(PREC);
          state <= ITER;
        end
        ITER: begin
          if (ge) begin
            r <= r - d_sh;
            quotient[i] <= 1'b1;
          end
          i <= i - 1'b1;
          cnt <= cnt - 1'b1;
          // after the last bit, i already points at the round position s-PREC
          if (cnt == 1) begin
`ifdef APPROX_DIV_ROUND_EN
            if (approx) state <= ROUND;
            else begin
              out_valid <= 1'b1;
              state <= DONE;
            end
`else
            out_valid <= 1'b1;
            state <= DONE;
`endif
          end
        end
`ifdef APPROX_DIV_ROUND_EN
        ROUND: begin
          if (ge) quotient <= rsum[QUOT_W] ? '1 : rsum[QUOT_W-1:0];
          out_valid <= 1'b1;
          state <= DONE;
        end
`endif
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_approx_div.sv
// tb_approx_div: randomized scoreboard bench for approx_div with directed corner cases
module tb_approx_div;
  localparam int PREC = 8;
`ifdef APPROX_DIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  typedef struct {
    logic [63:0] q;
    logic dz;
    logic ap;
    int lat;
    int acc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready;
  logic [63:0] dividend = '0, quotient;
  logic [31:0] divisor = '0;
  logic div_by_zero, approx;
  int cyc = 0, nvec = 0, ncmp = 0, errs = 0, mode = 0, vcnt = 0;
  int rise = 0, hs_edge = 0, last_acc = 0, last_lat = 0;
  logic seen = 1'b0, hdz, hap, last_dz, last_ap;
  logic [63:0] hq, last_q;
  exp_t sb[$];
  approx_div #(.PREC(PREC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .div_by_zero(div_by_zero),
    .approx(approx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    ncmp++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask
  function automatic int msb(input logic [63:0] v);
    int m = 0;
    for (int k = 0; k < 64; k++) if (v[k]) m = k;
    return m;
  endfunction
  // reference: exact quotient with everything below the top PREC aligned bits cleared
  function automatic exp_t model(input logic [63:0] n, input logic [31:0] d);
    exp_t e;
    logic [63:0] ex;
    logic [64:0] sum;
    int s, nb, sh, j;
    e.q = '0; e.dz = 1'b0; e.ap = 1'b0; e.lat = 1; e.acc = 0;
    if (d == 0) begin
      e.q = '1;
      e.dz = 1'b1;
    end else if (n >= 64'(d)) begin
      ex = n / 64'(d);
      s = msb(n) - msb(64'(d));
      nb = (s + 1 < PREC) ? s + 1 : PREC;
      sh = s - nb + 1;
      e.q = (ex >> sh) << sh;
      e.ap = (s + 1 > PREC);
      e.lat = nb + 1;
      if (RND && e.ap) begin
        j = s - PREC;
        if (ex[j]) begin
          sum = {1'b0, e.q} + (65'd1 << (j + 1));
          e.q = sum[64] ? '1 : sum[63:0];
        end
        e.lat++;
      end
    end
    return e;
  endfunction
  task automatic send(input logic [63:0] n, input logic [31:0] d);
    exp_t e;
    int k = 0;
    @(negedge clk);
    dividend = n;
    divisor = d;
    in_valid = 1'b1;
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      ncmp++;
      errs++;
      $display("FAIL accept_timeout: in_ready got 0 want 1");
    end else begin
      e = model(n, d);
      e.acc = cyc + 1;
      last_acc = e.acc;
      sb.push_back(e);
      nvec++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      ncmp++;
      errs++;
      $display("FAIL drain_timeout: pending %0d want 0", sb.size());
    end
  endtask
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vcnt = out_valid ? vcnt + 1 : 0;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom) : (vcnt > 3);
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      seen = 1'b0;
    end else if (out_valid) begin
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      if (!seen) begin
        seen = 1'b1;
        rise = cyc;
        hq = quotient;
        hdz = div_by_zero;
        hap = approx;
        if (sb.size() == 0) begin
          ncmp++;
          errs++;
          $display("FAIL unexpected_result: quotient %h with no pending operation", quotient);
        end
      end else begin
        chk("hold_quotient", quotient, hq);
        chk("hold_flags", {62'd0, div_by_zero, approx}, {62'd0, hdz, hap});
      end
      if (out_ready) begin
        hs_edge = cyc + 1;
        seen = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
          chk("approx", 64'(approx), 64'(e.ap));
          chk("latency", 64'(rise - e.acc), 64'(e.lat));
          last_q = quotient;
          last_dz = div_by_zero;
          last_ap = approx;
          last_lat = rise - e.acc;
        end
      end
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc2;
    logic [63:0] rn;
    logic [31:0] rd;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", quotient, 64'd0);
    chk("rst_flags", {62'd0, div_by_zero, approx}, 64'd0);
    rst_n = 1'b1;
    send(64'd100, 32'd7);
    drain();
    chk("small_q", last_q, 64'd14);
    chk("small_flags", {62'd0, last_dz, last_ap}, 64'd0);
    chk("small_lat", 64'(last_lat), 64'd6);
    send(64'hFFFF_FFFF_FFFF_FFFF, 32'd3);
    drain();
    chk("wide_q", last_q, RND ? 64'h5580_0000_0000_0000 : 64'h5500_0000_0000_0000);
    chk("wide_ap", 64'(last_ap), 64'd1);
    chk("wide_lat", 64'(last_lat), RND ? 64'd10 : 64'd9);
    send(64'd1234, 32'd0);
    drain();
    chk("dz_q", last_q, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dz_flag", 64'(last_dz), 64'd1);
    chk("dz_lat", 64'(last_lat), 64'd1);
    send(64'd5, 32'd9);
    drain();
    chk("lt_q", last_q, 64'd0);
    chk("lt_ap", 64'(last_ap), 64'd0);
    chk("lt_lat", 64'(last_lat), 64'd1);
    mode = 2;
    send(64'd1000, 32'd3);
    send(64'd77, 32'd5);
    acc2 = last_acc;
    chk("bp_next_accept", 64'(acc2), 64'(hs_edge + 1));
    drain();
    mode = 0;
    send(64'hFFFF_FFFF_FFFF_FFFF, 32'd3);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_quotient", quotient, 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_result", 64'(out_valid), 64'd0);
    mode = 1;
    for (int v = 0; v < 200; v++) begin
      rn = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
      rd = 32'($urandom) >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) rd = '0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rn, rd);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
